// File: rtl/busca_pkg.sv
// Shared definitions for the instruction-fetch block: widths, FSM state
// encoding, instruction-register field positions and the wait timeout limit.
// The timeout logic that uses TIMEOUT_MAX is built only when the
// BUSCA_TIMEOUT_EN macro is defined.
package busca_pkg;

  // Datapath widths
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int IMM_W   = 5;

  // Instruction-register field positions
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 13;
  localparam int BV_MSB     = 12;
  localparam int BV_LSB     = 11;
  localparam int RA_MSB     = 10;
  localparam int RA_LSB     = 8;
  localparam int RB_MSB     = 7;
  localparam int RB_LSB     = 5;
  localparam int IMM_MSB    = 4;
  localparam int IMM_LSB    = 0;

  // Memory wait timeout: number of consecutive WAIT cycles without data
  localparam int TIMEOUT_MAX = 15;
  localparam int WAIT_CNT_W  = $clog2(TIMEOUT_MAX + 1);
  // Counter value seen during the last tolerated WAIT cycle
  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_LAST = WAIT_CNT_W'(TIMEOUT_MAX - 1);

  // Fetch/execute sequencer states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Sign-extend the immediate offset to the program-counter width
  function automatic logic [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(PC_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/busca_pc_next.sv
// Next program-counter selection used in the EXEC state.
// Priority: stop holds pc, jump and taken branch go to pc+1+sext(imm),
// esc_pc advances to pc+1, otherwise pc holds. Arithmetic wraps at 256.
module busca_pc_next
  import busca_pkg::*;
(
  input  logic [PC_W-1:0]  pc,
  input  logic [IMM_W-1:0] imm,
  input  logic             stop,
  input  logic             ji,
  input  logic             beqz,
  input  logic             esc_pc,
  input  logic             zero,
  output logic [PC_W-1:0]  pc_next
);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_target;

  // Wrapping sums: the adder simply drops the carry out of bit PC_W-1
  assign pc_inc    = pc + 1'b1;
  assign pc_target = pc_inc + sext_imm(imm);

  // Priority select of the next program counter
  always_comb begin
    // NOTE: pc_next gets a value before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pc_next = pc;
    if (stop) begin
      pc_next = pc;
    end else if (ji) begin
      pc_next = pc_target;
    end else if (beqz && zero) begin
      pc_next = pc_target;
    end else if (esc_pc) begin
      pc_next = pc_inc;
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch unit: FETCH -> WAIT -> DECODE -> EXEC sequencer that
// reads a 16-bit instruction word, exposes its fields to the control unit
// and updates the program counter from the control unit's registered
// decisions. STOP parks the unit in HALT until reset.
// Optional feature: define BUSCA_TIMEOUT_EN to add a memory wait timeout
// that raises erro and halts after TIMEOUT_MAX silent WAIT cycles; without
// it WAIT waits indefinitely and erro is tied low.
module busca_instrucao
  import busca_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_valid,
  output logic [2:0]         opcode,
  output logic [1:0]         BitVerificacao,
  output logic [2:0]         ra,
  output logic [2:0]         rb,
  output logic [IMM_W-1:0]   imm,
  input  logic               STOP,
  input  logic               EscPC,
  input  logic               Ji,
  input  logic               Beqz,
  input  logic               zero,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               erro
);

  state_t             state;
  state_t             state_next;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    pc_next;
  logic               timeout_hit;

  // Next-pc selection for the EXEC state
  busca_pc_next u_pc_next (
    .pc      (pc),
    .imm     (ir[IMM_MSB:IMM_LSB]),
    .stop    (STOP),
    .ji      (Ji),
    .beqz    (Beqz),
    .esc_pc  (EscPC),
    .zero    (zero),
    .pc_next (pc_next)
  );

`ifdef BUSCA_TIMEOUT_EN
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  erro_q;

  assign timeout_hit = (state == ST_WAIT) && !mem_valid && (wait_cnt == WAIT_CNT_LAST);
  assign erro        = erro_q;

  // Count consecutive silent WAIT cycles and latch the timeout error
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      erro_q   <= 1'b0;
    end else if ((state == ST_WAIT) && !mem_valid) begin
      if (timeout_hit) begin
        erro_q <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign erro        = 1'b0;
`endif

  // Sequencer next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (mem_valid) begin
          state_next = ST_DECODE;
        end else if (timeout_hit) begin
          state_next = ST_HALT;
        end
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   state_next = STOP ? ST_HALT : ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_FETCH;
    endcase
  end

  // State, instruction register and program counter
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      if ((state == ST_WAIT) && mem_valid) begin
        ir <= mem_rdata;
      end
      if (state == ST_EXEC) begin
        pc <= pc_next;
      end
    end
  end

  // Request is a single-cycle pulse in FETCH, held low while reset is applied
  assign mem_req  = (state == ST_FETCH) && !reset;
  assign mem_addr = pc;
  assign halted   = (state == ST_HALT);

  // Instruction fields follow the IR continuously
  assign opcode         = ir[OPCODE_MSB:OPCODE_LSB];
  assign BitVerificacao = ir[BV_MSB:BV_LSB];
  assign ra             = ir[RA_MSB:RA_LSB];
  assign rb             = ir[RB_MSB:RB_LSB];
  assign imm            = ir[IMM_MSB:IMM_LSB];

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 SHALL be clocked by one clock; reset is synchronous and active-high.
REQ-002 Port: clock  in  1  system clock.
REQ-003 Port: reset  in  1  synchronous active-high reset.
REQ-004 Port: mem_req  out  1  instruction-memory read request, one-cycle pulse.
REQ-005 Port: mem_addr  out  8  word address of the request (equals pc).
REQ-006 Port: mem_rdata  in  16  instruction word, sampled only with mem_valid.
REQ-007 Port: mem_valid  in  1  read data valid.
REQ-008 Port: opcode  out  3  IR[15:13], to control unit.
REQ-009 Port: BitVerificacao  out  2  IR[12:11], to control unit.
REQ-010 Port: ra / rb  out  3 each  IR[10:8] / IR[7:5], register indices.
REQ-011 Port: imm  out  5  IR[4:0], signed offset.
REQ-012 Port: STOP, EscPC, Ji, Beqz  in  1 each  registered control-unit outputs.
REQ-013 Port: zero  in  1  datapath zero flag for Beqz.
REQ-014 Port: pc  out  8  current program counter.
REQ-015 Port: halted  out  1  high while in HALT.
REQ-016 Port: erro  out  1  memory timeout flag (see Configuration).

Function
REQ-017 FSM states: FETCH, WAIT, DECODE, EXEC, HALT.
REQ-018 FETCH: mem_req=1 and mem_addr=pc for exactly one cycle; next state WAIT.
REQ-019 WAIT: on mem_valid=1, load IR<=mem_rdata and go to DECODE; otherwise stay. mem_valid outside WAIT is ignored.
REQ-020 DECODE: lasts one cycle and presents IR fields so the control unit registers its outputs at the end of this cycle.
REQ-021 EXEC: lasts one cycle and samples STOP/Ji/Beqz/EscPC/zero; next state FETCH, or HALT if STOP.
REQ-022 PC update in EXEC, priority order: STOP -> pc unchanged; Ji -> pc+1+sext(imm); Beqz&zero -> pc+1+sext(imm); EscPC -> pc+1; else unchanged.
REQ-023 All pc arithmetic is modulo 256 (255+1 -> 0; 0+1+sext(-2) -> 255).
REQ-024 Beqz with zero=0 and EscPC=1 yields pc+1.
REQ-025 Opcode/field outputs reflect IR continuously; IR changes only on the WAIT capture.
REQ-026 HALT is absorbing until reset: mem_req=0, pc frozen, halted=1.
REQ-027 Minimum instruction period is 4 cycles (FETCH, WAIT with 1-cycle memory, DECODE, EXEC).

Reset
REQ-028 On reset: state=FETCH, pc=0, IR=0, mem_req=0, halted=0, erro=0.
REQ-029 Reset in any state, including WAIT with a read outstanding, abandons the cycle; the first post-reset fetch is at address 0.
REQ-030 The memory is reset together with this block; stale responses are outside scope.

Configuration
REQ-031 Macro BUSCA_TIMEOUT_EN defined: a 4-bit wait counter runs in WAIT; if mem_valid is absent for 15 consecutive WAIT cycles, erro latches to 1 and the state goes to HALT.
REQ-032 Macro BUSCA_TIMEOUT_EN undefined: there is no counter, WAIT is unbounded, and erro is tied to 0.

Structure
REQ-033 Package busca_pkg holds the state enum, IR field bit positions, widths (PC_W=8, INSTR_W=16, IMM_W=5), and TIMEOUT_MAX=15.
REQ-034 Sub-module busca_pc_next (combinational next-pc selection per REQ-022/023) is instantiated once.

Verification
REQ-035 Reset, then 1-cycle memory returning 16'h0000 (ADD) -> mem_req at cycles 0,4,8; addresses 0,1,2.
REQ-036 IR=16'hA003 (JUMP, imm=+3) at pc=5, Ji=1 in EXEC -> next mem_addr=9.
REQ-037 Beqz=1, EscPC=1, imm=5'b11110 at pc=0: zero=1 -> pc=255; zero=0 -> pc=1.
REQ-038 STOP=1 in EXEC at pc=7 -> halted=1, pc stays 7, no mem_req for 20 cycles; reset -> fetch at 0.
REQ-039 Reset asserted in WAIT before mem_valid -> next mem_req has addr 0, and IR stays 0 until new capture.
REQ-040 With BUSCA_TIMEOUT_EN, mem_valid is held 0 -> erro=1 and halted=1 after 15 WAIT cycles; without BUSCA_TIMEOUT_EN, the block stays in WAIT and erro=0.
